// File: rtl/rv_lsu.sv
// ============================================================================
//  Module   : rv_lsu
//  Brief    : RV64 load/store unit. Drives a req/gnt/rvalid data-memory bus,
//             stalls the pipeline until the access completes, lane-aligns
//             store data / byte enables, extends load data, and flags
//             misaligned or illegal-size accesses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_lsu #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              excp_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i
);

  localparam int NB = XLEN / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NB-1:0]   be_q, be_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            excp_q, excp_d;
  logic [2:0]      f3_q, f3_d;
  logic [2:0]      off_q, off_d;

  logic            acc;
  logic            is_store;
  logic            illegal;
  logic            misal;
  logic            bad;
  logic [NB-1:0]   size_mask;
  logic [NB-1:0]   be_new;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] rdata_sh;
  logic [XLEN-1:0] load_ext;

  // Decode the incoming request: legality, alignment and lane placement
  always_comb begin
    acc      = mem_read_i | mem_write_i;
    is_store = mem_write_i;  // read+write together resolves to a store
    illegal  = is_store ? funct3_i[2] : (funct3_i == 3'b111);
    case (funct3_i[1:0])
      2'd1:    misal = addr_i[0];
      2'd2:    misal = |addr_i[1:0];
      2'd3:    misal = |addr_i[2:0];
      default: misal = 1'b0;
    endcase
    bad = misal | illegal;
    case (funct3_i[1:0])
      2'd0:    size_mask = NB'(8'h01);
      2'd1:    size_mask = NB'(8'h03);
      2'd2:    size_mask = NB'(8'h0F);
      default: size_mask = NB'(8'hFF);
    endcase
    be_new   = size_mask << addr_i[2:0];
    wdata_sh = wdata_i << {addr_i[2:0], 3'b000};
    wdata_new = '0;
    // Lanes not enabled are driven to zero rather than carrying rs2 junk
    for (int i = 0; i < NB; i++) begin
      wdata_new[8*i +: 8] = be_new[i] ? wdata_sh[8*i +: 8] : 8'h00;
    end
  end

  // Extract the addressed bytes from the returned doubleword and extend
  always_comb begin
    rdata_sh = dmem_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{(XLEN-8){rdata_sh[7]}},   rdata_sh[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
      3'b010:  load_ext = {{(XLEN-32){rdata_sh[31]}}, rdata_sh[31:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}},          rdata_sh[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}},         rdata_sh[15:0]};
      3'b110:  load_ext = {{(XLEN-32){1'b0}},         rdata_sh[31:0]};
      default: load_ext = rdata_sh;
    endcase
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      excp_q  <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      excp_q  <= excp_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  // Next-state logic for the access sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (acc && !bad) state_d = S_REQ;
      S_REQ:   if (dmem_gnt_i) state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT:  if (dmem_rvalid_i) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values and the combinational stall
  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    done_d  = 1'b0;
    excp_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc && bad) begin
          excp_d = 1'b1;
        end else if (acc) begin
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {addr_i[XLEN-1:3], 3'b000};
          wdata_d = wdata_new;
          be_d    = be_new;
          f3_d    = funct3_i;
          off_d   = addr_i[2:0];
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          req_d  = 1'b0;
          done_d = we_q;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          rdata_d = load_ext;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
    stall_o = ~rst & acc & ~bad & (state_q != S_DONE);
  end

  assign done_o       = done_q;
  assign excp_o       = excp_q;
  assign rdata_o      = rdata_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_lsu.sv
// ============================================================================
//  Module   : tb_rv_lsu
//  Brief    : Directed self-checking bench for rv_lsu with a byte-level
//             reference model of alignment, lane placement and extension.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [63:0] addr_i = '0, wdata_i = '0;
  logic        stall_o, done_o, excp_o;
  logic [63:0] rdata_o;
  logic        dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o;
  logic [7:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [63:0] dmem_rdata_i = '0;

  rv_lsu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .excp_o(excp_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Expected per-cycle output values, set by the stimulus alongside inputs
  logic        chk_en = 1'b0;
  logic        e_stall = 1'b0, e_req = 1'b0, e_we = 1'b0, e_done = 1'b0, e_excp = 1'b0;
  logic [63:0] e_addr = '0, e_wdata = '0, e_rdata = '0;
  logic [7:0]  e_be = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model (byte-level) ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_bad(input logic st, input logic [2:0] f3, input logic [63:0] a);
    if (st ? f3[2] : (f3 == 3'b111)) return 1'b1;
    return (int'(a[2:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [7:0] model_be(input logic [2:0] f3, input logic [63:0] a);
    logic [7:0] b = '0;
    for (int i = 0; i < nbytes(f3); i++) b[int'(a[2:0]) + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [2:0] f3, input logic [63:0] a,
                                               input logic [63:0] d);
    logic [63:0] w = '0;
    for (int i = 0; i < nbytes(f3); i++) w[8*(int'(a[2:0]) + i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] a,
                                              input logic [63:0] rd);
    logic [63:0] v = '0;
    int n = nbytes(f3);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(int'(a[2:0]) + i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_o", 64'(stall_o), 64'(e_stall));
      chk("dmem_req_o", 64'(dmem_req_o), 64'(e_req));
      chk("done_o", 64'(done_o), 64'(e_done));
      chk("excp_o", 64'(excp_o), 64'(e_excp));
      chk("rdata_o", rdata_o, e_rdata);
      if (e_req) begin
        chk("dmem_we_o", 64'(dmem_we_o), 64'(e_we));
        chk("dmem_addr_o", dmem_addr_o, e_addr);
        chk("dmem_be_o", 64'(dmem_be_o), 64'(e_be));
        if (e_we) chk("dmem_wdata_o", dmem_wdata_o, e_wdata);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    funct3_i    = 3'b000;
    addr_i      = '0;
    wdata_i     = '0;
  endtask

  // One complete access with given grant / rvalid delays; returns bus fields
  // captured in the first request cycle.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] rdat, input int gd, input int rvd,
                        output logic [7:0] cap_be, output logic [63:0] cap_wd,
                        output logic [63:0] cap_addr);
    logic st  = wr;
    logic bad = model_bad(wr, f3, a);
    cap_be = '0; cap_wd = '0; cap_addr = '0;
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
    e_stall = !bad; e_req = 1'b0; e_done = 1'b0; e_excp = 1'b0;
    cyc();
    if (bad) begin
      idle_inputs();
      e_stall = 1'b0; e_excp = 1'b1;
      cyc();
      e_excp = 1'b0;
      return;
    end
    e_req = 1'b1; e_we = st; e_addr = {a[63:3], 3'b000};
    e_be = model_be(f3, a); e_wdata = model_wdata(f3, a, wd);
    for (int k = 0; k <= gd; k++) begin
      dmem_gnt_i = (k == gd);
      @(negedge clk);
      if (k == 0) begin
        cap_be = dmem_be_o; cap_wd = dmem_wdata_o; cap_addr = dmem_addr_o;
      end
      cyc();
    end
    dmem_gnt_i = 1'b0;
    e_req = 1'b0;
    if (!st) begin
      for (int j = 0; j <= rvd; j++) begin
        dmem_rvalid_i = (j == rvd);
        dmem_rdata_i  = (j == rvd) ? rdat : 64'hDEAD_BEEF_0BAD_F00D;
        cyc();
      end
      dmem_rvalid_i = 1'b0;
      e_rdata = model_load(f3, a, rdat);
    end
    e_done = 1'b1; e_stall = 1'b0;
    cyc();
    e_done = 1'b0;
    idle_inputs();
  endtask

  logic [7:0]  c_be;
  logic [63:0] c_wd, c_addr;

  initial begin
    // Reset: outputs zero, stall masked even with a legal access presented
    cyc();
    mem_read_i = 1'b1; funct3_i = 3'b011; addr_i = 64'h1000;
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    idle_inputs();

    // SD, grant with request: done in cycle 3
    access(1'b0, 1'b1, 3'b011, 64'h1000, 64'h1122334455667788, '0, 0, 0, c_be, c_wd, c_addr);
    chk("lit_sd_be", 64'(c_be), 64'hFF);
    chk("lit_sd_addr", c_addr, 64'h1000);
    chk("lit_sd_wdata", c_wd, 64'h1122334455667788);

    // SB with junk in the upper rs2 bytes
    access(1'b0, 1'b1, 3'b000, 64'h1005, 64'hDEADBEEF_CAFE00AB, '0, 0, 0, c_be, c_wd, c_addr);
    chk("lit_sb_be", 64'(c_be), 64'h20);
    chk("lit_sb_wdata", c_wd, 64'h0000AB0000000000);
    chk("lit_sb_addr", c_addr, 64'h1000);

    access(1'b1, 1'b0, 3'b000, 64'h2003, '0, 64'h00000000_80000000, 0, 0, c_be, c_wd, c_addr);
    chk("lit_lb", rdata_o, 64'hFFFFFFFFFFFFFF80);
    access(1'b1, 1'b0, 3'b100, 64'h2003, '0, 64'h00000000_80000000, 0, 0, c_be, c_wd, c_addr);
    chk("lit_lbu", rdata_o, 64'h80);
    access(1'b1, 1'b0, 3'b010, 64'h2004, '0, 64'h89ABCDEF_01234567, 1, 2, c_be, c_wd, c_addr);
    chk("lit_lw", rdata_o, 64'hFFFFFFFF89ABCDEF);
    access(1'b1, 1'b0, 3'b110, 64'h2004, '0, 64'h89ABCDEF_01234567, 0, 1, c_be, c_wd, c_addr);
    chk("lit_lwu", rdata_o, 64'h0000000089ABCDEF);

    // Store leaves rdata_o alone; read+write together acts as a store
    access(1'b1, 1'b1, 3'b010, 64'h1008, 64'h0000_0000_CAFEF00D, '0, 2, 0, c_be, c_wd, c_addr);
    chk("lit_sw_be", 64'(c_be), 64'h0F);
    chk("lit_sw_keep_rdata", rdata_o, 64'h0000000089ABCDEF);
    access(1'b0, 1'b1, 3'b001, 64'h1006, 64'h0000_0000_0000_BEEF, '0, 1, 0, c_be, c_wd, c_addr);
    chk("lit_sh_wdata", c_wd, 64'hBEEF000000000000);
    access(1'b1, 1'b0, 3'b101, 64'h2006, '0, 64'hF00D_1234_5678_9ABC, 0, 0, c_be, c_wd, c_addr);
    chk("lit_lhu", rdata_o, 64'h000000000000F00D);
    access(1'b1, 1'b0, 3'b001, 64'h2002, '0, 64'hF00D_1234_8678_9ABC, 0, 0, c_be, c_wd, c_addr);
    chk("lit_lh", rdata_o, 64'hFFFFFFFFFFFF8678);
    access(1'b1, 1'b0, 3'b011, 64'h2000, '0, 64'h0123_4567_89AB_CDEF, 3, 1, c_be, c_wd, c_addr);
    chk("lit_ld", rdata_o, 64'h0123456789ABCDEF);

    // Exceptions: misaligned LH, illegal load, misaligned SW, illegal store
    access(1'b1, 1'b0, 3'b001, 64'h3001, '0, '0, 0, 0, c_be, c_wd, c_addr);
    access(1'b1, 1'b0, 3'b111, 64'h3000, '0, '0, 0, 0, c_be, c_wd, c_addr);
    access(1'b0, 1'b1, 3'b010, 64'h1002, 64'h55, '0, 0, 0, c_be, c_wd, c_addr);
    access(1'b0, 1'b1, 3'b100, 64'h1000, 64'h55, '0, 0, 0, c_be, c_wd, c_addr);
    access(1'b1, 1'b0, 3'b011, 64'h3004, '0, '0, 0, 0, c_be, c_wd, c_addr);

    // LD with grant delayed 3 cycles, then reset while waiting for rvalid
    mem_read_i = 1'b1; funct3_i = 3'b011; addr_i = 64'h2008;
    e_stall = 1'b1; e_req = 1'b0;
    cyc();
    e_req = 1'b1; e_we = 1'b0; e_addr = 64'h2008; e_be = 8'hFF;
    for (int k = 0; k <= 3; k++) begin
      dmem_gnt_i = (k == 3);
      cyc();
    end
    dmem_gnt_i = 1'b0; e_req = 1'b0;
    rst = 1'b1; e_stall = 1'b0;
    cyc();
    rst = 1'b0; idle_inputs(); e_rdata = '0;
    cyc();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    dmem_rvalid_i = 1'b0;
    cyc();
    chk("lit_rst_req", 64'(dmem_req_o), 64'h0);

    // Normal operation after the mid-access reset
    access(1'b1, 1'b0, 3'b000, 64'h2007, '0, 64'h7F00_0000_0000_0000, 0, 0, c_be, c_wd, c_addr);
    chk("lit_lb_after_rst", rdata_o, 64'h7F);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
